// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit shifter between two requesters,
// each with a valid/ready request channel and a registered one-entry response slot.
module shift_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SHAMT_W    = 5,
    parameter int unsigned FIRST_PRIO = 0
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_operand,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [1:0]         req0_type,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [DATA_W-1:0]  rsp0_result,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_operand,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [1:0]         req1_type,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp1_result,

    output logic [DATA_W-1:0]  sh_operand,
    output logic [SHAMT_W-1:0] sh_shamt,
    output logic [1:0]         sh_type,
    input  logic [DATA_W-1:0]  sh_result
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

    localparam logic [1:0] TYPE_SLL  = 2'b00;
    localparam logic [1:0] TYPE_PASS = 2'b11;

    slot_t slot0;
    slot_t slot1;
    logic  last_grant;
    logic  eligible0;
    logic  eligible1;
    logic  grant0;
    logic  grant1;

    // A full slot still counts as free when its consumer drains it this cycle.
    assign eligible0 = req0_valid && ((slot0 == SLOT_EMPTY) || rsp0_ready);
    assign eligible1 = req1_valid && ((slot1 == SLOT_EMPTY) || rsp1_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (eligible0 && eligible1) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = eligible0;
                grant1 = eligible1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = (slot0 == SLOT_FULL);
    assign rsp1_valid = (slot1 == SLOT_FULL);

    // Pass-through requests still occupy the shifter slot but drive a no-op shift.
    always_comb begin
        sh_operand = '0;
        sh_shamt   = '0;
        sh_type    = TYPE_SLL;
        if (grant0) begin
            sh_operand = req0_operand;
            if (req0_type != TYPE_PASS) begin
                sh_shamt = req0_shamt;
                sh_type  = req0_type;
            end
        end else if (grant1) begin
            sh_operand = req1_operand;
            if (req1_type != TYPE_PASS) begin
                sh_shamt = req1_shamt;
                sh_type  = req1_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= (FIRST_PRIO == 0);
            slot0       <= SLOT_EMPTY;
            slot1       <= SLOT_EMPTY;
            rsp0_result <= '0;
            rsp1_result <= '0;
        end else begin
            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end

            if (grant0) begin
                slot0       <= SLOT_FULL;
                rsp0_result <= (req0_type == TYPE_PASS) ? req0_operand : sh_result;
            end else if (rsp0_ready) begin
                slot0 <= SLOT_EMPTY;
            end

            if (grant1) begin
                slot1       <= SLOT_FULL;
                rsp1_result <= (req1_type == TYPE_PASS) ? req1_operand : sh_result;
            end else if (rsp1_ready) begin
                slot1 <= SLOT_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter; the bench supplies the combinational shifter itself.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [31:0] req0_operand, rsp0_result;
    logic [4:0]  req0_shamt;
    logic [1:0]  req0_type;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req1_operand, rsp1_result;
    logic [4:0]  req1_shamt;
    logic [1:0]  req1_type;
    logic [31:0] sh_operand, sh_result;
    logic [4:0]  sh_shamt;
    logic [1:0]  sh_type;

    int n_checks = 0;
    int n_fail   = 0;
    int bad_type_cnt = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .FIRST_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_operand(req0_operand),
        .req0_shamt(req0_shamt), .req0_type(req0_type),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_operand(req1_operand),
        .req1_shamt(req1_shamt), .req1_type(req1_type),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .sh_operand(sh_operand), .sh_shamt(sh_shamt), .sh_type(sh_type),
        .sh_result(sh_result)
    );

    always_comb begin
        case (sh_type)
            2'b00:   sh_result = sh_operand << sh_shamt;
            2'b01:   sh_result = sh_operand >> sh_shamt;
            2'b10:   sh_result = $unsigned($signed(sh_operand) >>> sh_shamt);
            default: sh_result = 32'hBAD0_BAD0;
        endcase
    end

    always @(negedge clk) if (sh_type == 2'b11) bad_type_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_operand = '0; req0_shamt = '0; req0_type = 2'b00;
        req1_valid = 1'b0; req1_operand = '0; req1_shamt = '0; req1_type = 2'b00;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        n_checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 00", {rsp0_valid, rsp1_valid});
        end
        n_checks++;
        if ({rsp0_result, rsp1_result} !== 64'h0) begin
            n_fail++; $display("FAIL reset_result: got %h/%h expected 0/0", rsp0_result, rsp1_result);
        end
        n_checks++;
        if ({sh_operand, sh_shamt, sh_type, req0_ready, req1_ready} !== 41'h0) begin
            n_fail++; $display("FAIL idle_sh: got op=%h sh=%0d ty=%b rdy=%b%b expected all 0",
                               sh_operand, sh_shamt, sh_type, req0_ready, req1_ready);
        end
        // Fill slot0 then reset while it is full.
        req0_valid = 1'b1; req0_operand = 32'h1; req0_shamt = 5'd1; req0_type = 2'b00;
        step();
        req0_valid = 1'b0;
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h2) begin
            n_fail++; $display("FAIL fill_slot0: got v=%b r=%h expected v=1 r=00000002", rsp0_valid, rsp0_result);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (rsp0_valid !== 1'b0 || rsp0_result !== 32'h0) begin
            n_fail++; $display("FAIL reset_full: got v=%b r=%h expected v=0 r=0", rsp0_valid, rsp0_result);
        end
    endtask

    task automatic test_sra();
        apply_reset();
        req0_valid = 1'b1; req0_operand = 32'h8000_00F0; req0_shamt = 5'd4; req0_type = 2'b10;
        rsp0_ready = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || sh_type !== 2'b10 || sh_operand !== 32'h8000_00F0 || sh_shamt !== 5'd4) begin
            n_fail++; $display("FAIL sra_grant: got rdy=%b ty=%b op=%h sh=%0d expected 1 10 800000f0 4",
                               req0_ready, sh_type, sh_operand, sh_shamt);
        end
        n_checks++;
        if (rsp0_valid !== 1'b0) begin
            n_fail++; $display("FAIL sra_latency: got rsp0_valid=%b expected 0 before edge", rsp0_valid);
        end
        step();
        req0_valid = 1'b0;
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'hF800_000F) begin
            n_fail++; $display("FAIL sra_result: got v=%b r=%h expected v=1 r=f800000f", rsp0_valid, rsp0_result);
        end
        step();
        n_checks++;
        if (rsp0_valid !== 1'b0) begin
            n_fail++; $display("FAIL sra_drain: got rsp0_valid=%b expected 0", rsp0_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] op0 [2] = '{32'h3, 32'hF0};
        logic [4:0]  sh0 [2] = '{5'd2, 5'd4};
        logic [1:0]  ty0 [2] = '{2'b00, 2'b01};
        logic [31:0] ex0 [2] = '{32'hC, 32'hF};
        logic [31:0] op1 [2] = '{32'h8000_0000, 32'h1};
        logic [4:0]  sh1 [2] = '{5'd31, 5'd8};
        logic [1:0]  ty1 [2] = '{2'b10, 2'b00};
        logic [31:0] ex1 [2] = '{32'hFFFF_FFFF, 32'h100};
        int i0, i1;
        apply_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i0 = (i + 1) / 2;
            i1 = i / 2;
            req0_valid = (i0 < 2);
            if (i0 < 2) begin
                req0_operand = op0[i0]; req0_shamt = sh0[i0]; req0_type = ty0[i0];
            end
            req1_valid = 1'b1;
            req1_operand = op1[i1]; req1_shamt = sh1[i1]; req1_type = ty1[i1];
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got rdy0/1=%b%b expected port %0d",
                                   i, req0_ready, req1_ready, i % 2);
            end
            step();
            n_checks++;
            if (i % 2 == 0) begin
                if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_result !== ex0[i / 2]) begin
                    n_fail++; $display("FAIL rr_rsp[%0d]: got v=%b%b r0=%h expected v=10 r0=%h",
                                       i, rsp0_valid, rsp1_valid, rsp0_result, ex0[i / 2]);
                end
            end else begin
                if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b1 || rsp1_result !== ex1[i / 2]) begin
                    n_fail++; $display("FAIL rr_rsp[%0d]: got v=%b%b r1=%h expected v=01 r1=%h",
                                       i, rsp0_valid, rsp1_valid, rsp1_result, ex1[i / 2]);
                end
            end
        end
        idle_inputs();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step();
        n_checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rr_once: got v=%b%b expected 00", rsp0_valid, rsp1_valid);
        end
    endtask

    task automatic test_full_slot();
        apply_reset();
        req0_valid = 1'b1; req0_operand = 32'h100; req0_shamt = 5'd4; req0_type = 2'b01;
        step();
        req0_operand = 32'h5; req0_shamt = 5'd1; req0_type = 2'b00;
        req1_valid = 1'b1; req1_operand = 32'h1; req1_shamt = 5'd31; req1_type = 2'b00;
        rsp1_ready = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++; $display("FAIL full_stall: got rdy0/1=%b%b expected 01", req0_ready, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        n_checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h8000_0000) begin
            n_fail++; $display("FAIL full_other: got v=%b r=%h expected v=1 r=80000000", rsp1_valid, rsp1_result);
        end
        step();
        n_checks++;
        if (req0_ready !== 1'b0 || rsp0_valid !== 1'b1 || rsp0_result !== 32'h10) begin
            n_fail++; $display("FAIL full_hold: got rdy=%b v=%b r=%h expected rdy=0 v=1 r=00000010",
                               req0_ready, rsp0_valid, rsp0_result);
        end
        rsp0_ready = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL drain_accept: got req0_ready=%b expected 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'hA) begin
            n_fail++; $display("FAIL overwrite: got v=%b r=%h expected v=1 r=0000000a", rsp0_valid, rsp0_result);
        end
        step();
        n_checks++;
        if (rsp0_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_drain: got rsp0_valid=%b expected 0", rsp0_valid);
        end
    endtask

    task automatic test_passthrough();
        apply_reset();
        req1_valid = 1'b1; req1_operand = 32'hDEAD_BEEF; req1_shamt = 5'd7; req1_type = 2'b11;
        rsp1_ready = 1'b1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || sh_type !== 2'b00 || sh_shamt !== 5'd0 || sh_operand !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL pass_drive: got rdy=%b ty=%b sh=%0d op=%h expected 1 00 0 deadbeef",
                               req1_ready, sh_type, sh_shamt, sh_operand);
        end
        step();
        req1_valid = 1'b0;
        n_checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL pass_result: got v=%b r=%h expected v=1 r=deadbeef", rsp1_valid, rsp1_result);
        end
        step();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        rsp1_ready = 1'b1;
        req1_valid = 1'b1; req1_operand = 32'hFFFF_FFFF; req1_type = 2'b01;
        for (int k = 0; k < 32; k++) begin
            req1_shamt = k[4:0];
            #1;
            n_checks++;
            if (req1_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", k, req1_ready);
            end
            step();
            n_checks++;
            if (rsp1_valid !== 1'b1 || rsp1_result !== (32'hFFFF_FFFF >> k)) begin
                n_fail++; $display("FAIL stream_result[%0d]: got v=%b r=%h expected v=1 r=%h",
                                   k, rsp1_valid, rsp1_result, 32'hFFFF_FFFF >> k);
            end
        end
        req1_valid = 1'b0;
        step();
        n_checks++;
        if (rsp1_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_end: got rsp1_valid=%b expected 0", rsp1_valid);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_sra();
        test_round_robin();
        test_full_slot();
        test_passthrough();
        test_back_to_back();
        n_checks++;
        if (bad_type_cnt !== 0) begin
            n_fail++; $display("FAIL sh_type_11: got %0d cycles with sh_type=11 expected 0", bad_type_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
